rob_alloc_ctrl: RTL

- Owns the ROB occupancy bookkeeping and sequences allocation for the dual-issue rename stage.
- Each cycle it grants up to two new ROB ids in program order and reclaims up to two ids retired by commit.
- On flush it runs a fixed post-flush drain before re-opening allocation.
- Sits between decode/rename (allocation side) and commit (retire/flush side); rename consumes alloc_id_o as destination physical tags.

---
 rtl/rob_alloc_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: ROB occupancy bookkeeping and in-order id allocation for a
// dual-issue rename stage. It grants up to two ids per cycle at the tail and
// reclaims up to two retired ids per cycle at the head. A flush empties the ROB
// and closes allocation for FLUSH_STALL cycles.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   alloc_req_i    per-slot allocation request (bit0 = older slot)
//   alloc_ready_o  allocation accepted this cycle
//   alloc_id_o     ids for slot0/slot1 (valid whenever requested)
//   alloc_fire_o   granted slots
//   retire_i       entries retired at head (bit1 only valid with bit0)
//   flush_i        pipeline flush
//   head_o/tail_o  oldest live entry / next entry to allocate
//   count_o        live entries, empty_o/full_o derived from it
//   err_o          sticky retire protocol violation
//
// state | meaning
// RUN   | normal operation, allocation open subject to occupancy
// DRAIN | post-flush stall, allocation closed
module rob_alloc_ctrl #(
  parameter int ROB_DEPTH   = 64,
  parameter int ROB_WIDTH   = 6,
  parameter int RESERVE     = 2,
  parameter int FLUSH_STALL = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                alloc_req_i,
  output logic                      alloc_ready_o,
  output logic [1:0][ROB_WIDTH-1:0] alloc_id_o,
  output logic [1:0]                alloc_fire_o,
  input  logic [1:0]                retire_i,
  input  logic                      flush_i,
  output logic [ROB_WIDTH-1:0]      head_o,
  output logic [ROB_WIDTH-1:0]      tail_o,
  output logic [ROB_WIDTH:0]        count_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      err_o
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [ROB_WIDTH:0] READY_MAX = (ROB_WIDTH+1)'(ROB_DEPTH - 2 - RESERVE);
  localparam logic [ROB_WIDTH:0] FULL_CNT  = (ROB_WIDTH+1)'(ROB_DEPTH);
  localparam logic [3:0]         DRAIN_LD  = 4'(FLUSH_STALL - 1);

  state_t                 state_q, state_d;
  logic [3:0]             drain_q, drain_d;
  logic [ROB_WIDTH-1:0]   head_q, tail_q;
  logic [ROB_WIDTH:0]     count_q;
  logic                   err_q;

  logic [1:0]             nalloc;
  logic [1:0]             ret_pop;
  logic [1:0]             nretire;
  logic                   viol;

  assign alloc_ready_o = (state_q == RUN) && !flush_i && (count_q <= READY_MAX);
  assign alloc_fire_o  = alloc_req_i & {2{alloc_ready_o}};

  // Slot1 gets tail only when slot0 is not requesting, so ids stay hole-free.
  assign alloc_id_o[0] = tail_q;
  assign alloc_id_o[1] = tail_q + ROB_WIDTH'(alloc_req_i[0]);

  assign nalloc  = {1'b0, alloc_fire_o[0]} + {1'b0, alloc_fire_o[1]};
  assign ret_pop = {1'b0, retire_i[0]} + {1'b0, retire_i[1]};

  // Retire is clamped to the live count so count never underflows.
  always_comb begin
    viol    = (retire_i == 2'b10);
    nretire = ret_pop;
    if ((ROB_WIDTH+1)'(ret_pop) > count_q) begin
      viol    = 1'b1;
      nretire = count_q[1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (flush_i) begin
      state_d = DRAIN;
      drain_d = DRAIN_LD;
    end else begin
      case (state_q)
        RUN:   ;
        DRAIN: begin
          if (drain_q == 4'd0) state_d = RUN;
          else                 drain_d = drain_q - 4'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= 4'd0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (flush_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_q + ROB_WIDTH'(nretire);
        tail_q  <= tail_q + ROB_WIDTH'(nalloc);
        count_q <= count_q + (ROB_WIDTH+1)'(nalloc) - (ROB_WIDTH+1)'(nretire);
        // Retires on a flush cycle are discarded, so they cannot violate.
        if (viol) err_q <= 1'b1;
      end
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign err_o   = err_q;

endmodule
